// File: rtl/picobello_pkg.sv
// Shared constants, flush FSM states and default AXI4+ATOP channel types for the
// picobello transaction throttle.
package picobello_pkg;

  localparam int unsigned DefaultMaxReads      = 8;
  localparam int unsigned DefaultMaxWrites     = 8;
  localparam int unsigned DefaultTimeoutCycles = 1024;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } flush_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } pb_aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } pb_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } pb_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } pb_ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } pb_r_chan_t;

  typedef struct packed {
    pb_aw_chan_t aw;
    logic        aw_valid;
    pb_w_chan_t  w;
    logic        w_valid;
    logic        b_ready;
    pb_ar_chan_t ar;
    logic        ar_valid;
    logic        r_ready;
  } pb_axi_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    logic       b_valid;
    pb_b_chan_t b;
    logic       r_valid;
    pb_r_chan_t r;
  } pb_axi_rsp_t;

endpackage

// File: rtl/picobello_updown_cnt.sv
// Saturating up/down counter: adds inc_i (0..2), subtracts dec_i, clamps to [0, MaxVal].
// clr_i has priority over counting.
module picobello_updown_cnt #(
  parameter int unsigned MaxVal = 8,
  parameter int unsigned Width  = $clog2(MaxVal + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [1:0]       inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o
);

  localparam int unsigned SumW = Width + 2;

  logic [Width-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]  sum;

  always_comb begin
    sum = {2'b00, cnt_q} + {{Width{1'b0}}, inc_i};
    if (dec_i && (sum != '0)) begin
      sum = sum - SumW'(1);
    end
    if (clr_i) begin
      cnt_d = '0;
    end else if (sum > SumW'(MaxVal)) begin
      cnt_d = Width'(MaxVal);
    end else begin
      cnt_d = sum[Width-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

  // A lone decrement at zero means a completion arrived for nothing outstanding.
  underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(dec_i && (inc_i == 2'd0) && (cnt_q == '0)));

endmodule

// File: rtl/picobello_axi_txn_throttle.sv
// AXI4 outstanding-transaction throttle with flush/quiesce handshake; only AW/AR valid/ready are gated.
// Optional stuck-transaction watchdog enabled by defining PICOBELLO_TXN_THROTTLE_TIMEOUT_EN.
module picobello_axi_txn_throttle
  import picobello_pkg::*;
#(
  parameter int unsigned MaxReads      = DefaultMaxReads,
  parameter int unsigned MaxWrites     = DefaultMaxWrites,
`ifdef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
`endif
  parameter type         axi_req_t     = picobello_pkg::pb_axi_req_t,
  parameter type         axi_rsp_t     = picobello_pkg::pb_axi_rsp_t
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  output logic                             flushed_o,
  output logic                             busy_o,
  output logic [$clog2(MaxReads+1)-1:0]    rd_cnt_o,
  output logic [$clog2(MaxWrites+1)-1:0]   wr_cnt_o,
`ifdef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
  output logic                             timeout_o,
`endif
  input  axi_req_t                         slv_req_i,
  output axi_rsp_t                         slv_rsp_o,
  output axi_req_t                         mst_req_o,
  input  axi_rsp_t                         mst_rsp_i
);

  // States: IDLE = traffic admitted | DRAIN = AW/AR blocked, waiting for zero | FLUSHED = quiesced
  localparam int unsigned RdW = $clog2(MaxReads + 1);
  localparam int unsigned WrW = $clog2(MaxWrites + 1);

  flush_state_e state_q, state_d;

  logic       ar_stall, aw_stall;
  logic       ar_hs, aw_hs, r_last_hs, b_hs;
  logic       aw_reads;
  logic [1:0] rd_inc;
  logic       rd_drained, wr_drained;

  // Stalls use only registered state and aw.atop, so ready never depends on valid.
  always_comb begin
    ar_stall = (rd_cnt_o == RdW'(MaxReads)) || (state_q != IDLE);
    aw_stall = (wr_cnt_o == WrW'(MaxWrites)) || (state_q != IDLE) ||
               (slv_req_i.aw.atop[5] && (rd_cnt_o == RdW'(MaxReads)));
  end

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~aw_stall;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~ar_stall;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & ~aw_stall;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ~ar_stall;
  end

  assign ar_hs     = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
  assign aw_hs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
  assign r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
  assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;
  assign aw_reads  = aw_hs & slv_req_i.aw.atop[5];
  assign rd_inc    = 2'(ar_hs) + 2'(aw_reads);

  picobello_updown_cnt #(
    .MaxVal ( MaxReads )
  ) u_rd_cnt (
    .clk_i  ( clk_i     ),
    .rst_ni ( rst_ni    ),
    .clr_i  ( 1'b0      ),
    .inc_i  ( rd_inc    ),
    .dec_i  ( r_last_hs ),
    .cnt_o  ( rd_cnt_o  )
  );

  picobello_updown_cnt #(
    .MaxVal ( MaxWrites )
  ) u_wr_cnt (
    .clk_i  ( clk_i         ),
    .rst_ni ( rst_ni        ),
    .clr_i  ( 1'b0          ),
    .inc_i  ( {1'b0, aw_hs} ),
    .dec_i  ( b_hs          ),
    .cnt_o  ( wr_cnt_o      )
  );

  // Outside IDLE nothing can increment, so "zero after this cycle" is zero or a final decrement.
  assign rd_drained = (rd_cnt_o == '0) || ((rd_cnt_o == RdW'(1)) && r_last_hs);
  assign wr_drained = (wr_cnt_o == '0) || ((wr_cnt_o == WrW'(1)) && b_hs);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!flush_i) begin
          state_d = IDLE;
        end else if (rd_drained && wr_drained) begin
          state_d = FLUSHED;
        end
      end
      FLUSHED: begin
        if (!flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign flushed_o = (state_q == FLUSHED);
  assign busy_o    = (rd_cnt_o != '0) || (wr_cnt_o != '0);

`ifdef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);

  logic [TmoW-1:0] tmo_cnt;
  logic            tmo_clr;
  logic            timeout_q;

  // Any completion proves forward progress and restarts the watchdog.
  assign tmo_clr = ~busy_o | r_last_hs | b_hs;

  picobello_updown_cnt #(
    .MaxVal ( TimeoutCycles )
  ) u_tmo_cnt (
    .clk_i  ( clk_i   ),
    .rst_ni ( rst_ni  ),
    .clr_i  ( tmo_clr ),
    .inc_i  ( 2'd1    ),
    .dec_i  ( 1'b0    ),
    .cnt_o  ( tmo_cnt )
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_q | (tmo_cnt == TmoW'(TimeoutCycles));
    end
  end

  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_picobello_axi_txn_throttle.sv
// Directed plus random bench for picobello_axi_txn_throttle against a count-based reference model.
// Timeout checks are included when PICOBELLO_TXN_THROTTLE_TIMEOUT_EN is defined.
module tb_picobello_axi_txn_throttle;
  import picobello_pkg::*;

  localparam int MaxR  = 2;
  localparam int MaxW  = 4;
  localparam int ToCyc = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flushed, busy;
  logic [1:0] rd_cnt;
  logic [2:0] wr_cnt;
  logic timeout;
  pb_axi_req_t slv_req, mst_req;
  pb_axi_rsp_t slv_rsp, mst_rsp;

  always #5 clk = ~clk;

  picobello_axi_txn_throttle #(
    .MaxReads      ( MaxR  ),
`ifdef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
    .TimeoutCycles ( ToCyc ),
`endif
    .MaxWrites     ( MaxW  )
  ) dut (
    .clk_i     ( clk     ),
    .rst_ni    ( rst_n   ),
    .flush_i   ( flush   ),
    .flushed_o ( flushed ),
    .busy_o    ( busy    ),
    .rd_cnt_o  ( rd_cnt  ),
    .wr_cnt_o  ( wr_cnt  ),
`ifdef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
    .timeout_o ( timeout ),
`endif
    .slv_req_i ( slv_req ),
    .slv_rsp_o ( slv_rsp ),
    .mst_req_o ( mst_req ),
    .mst_rsp_i ( mst_rsp )
  );

`ifndef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
  assign timeout = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  string phase = "reset";

  // stimulus knobs
  logic s_arv, s_awv, s_wv, s_rv, s_rlast, s_bv, s_rrdy, s_brdy;
  logic m_arrdy, m_awrdy, m_wrdy;
  logic [5:0]  s_atop;
  logic [63:0] s_rdata;

  // reference model: outstanding counts, quiesce mode (0 open, 1 draining, 2 quiesced), watchdog
  int m_rd = 0, m_wr = 0, m_mode = 0, m_tc = 0;
  bit m_to = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic clear();
    s_arv = 0; s_awv = 0; s_wv = 0; s_rv = 0; s_rlast = 0; s_bv = 0;
    s_rrdy = 1; s_brdy = 1; m_arrdy = 1; m_awrdy = 1; m_wrdy = 1;
    s_atop = 6'b0; s_rdata = 64'hA5A5_0000_1234_5678;
  endtask

  task automatic drive();
    slv_req = '0;
    mst_rsp = '0;
    slv_req.ar_valid = s_arv;
    slv_req.ar.id    = 4'h3;
    slv_req.ar.addr  = 32'h1000_0040;
    slv_req.aw_valid = s_awv;
    slv_req.aw.id    = 4'h5;
    slv_req.aw.addr  = 32'h1000_0080;
    slv_req.aw.atop  = s_atop;
    slv_req.w_valid  = s_wv;
    slv_req.w.last   = 1'b1;
    slv_req.r_ready  = s_rrdy;
    slv_req.b_ready  = s_brdy;
    mst_rsp.ar_ready = m_arrdy;
    mst_rsp.aw_ready = m_awrdy;
    mst_rsp.w_ready  = m_wrdy;
    mst_rsp.r_valid  = s_rv;
    mst_rsp.r.last   = s_rlast;
    mst_rsp.r.data   = s_rdata;
    mst_rsp.b_valid  = s_bv;
  endtask

  function automatic int clamp(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // One clock: apply knobs, check outputs against the model, advance the model.
  task automatic step();
    bit open, ar_ok, aw_ok, ar_hs, aw_hs, rl_hs, b_hs, busy_e;
    int rd_n, wr_n;
    drive();
    #1;
    open  = (m_mode == 0);
    ar_ok = open && (m_rd < MaxR);
    aw_ok = open && (m_wr < MaxW) && !(s_atop[5] && (m_rd == MaxR));
    busy_e = (m_rd != 0) || (m_wr != 0);
    chk("rd_cnt", rd_cnt, m_rd);
    chk("wr_cnt", wr_cnt, m_wr);
    chk("busy", busy, busy_e);
    chk("flushed", flushed, m_mode == 2);
    chk("ar_ready", slv_rsp.ar_ready, m_arrdy && ar_ok);
    chk("ar_valid", mst_req.ar_valid, s_arv && ar_ok);
    chk("aw_ready", slv_rsp.aw_ready, m_awrdy && aw_ok);
    chk("aw_valid", mst_req.aw_valid, s_awv && aw_ok);
    chk("wrb_fwd", {slv_rsp.r_valid, slv_rsp.b_valid, slv_rsp.w_ready, mst_req.w_valid},
        {s_rv, s_bv, m_wrdy, s_wv});
    chk("rdata_fwd", slv_rsp.r.data, s_rdata);
`ifdef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
    chk("timeout", timeout, m_to);
`endif
    ar_hs = s_arv && m_arrdy && ar_ok;
    aw_hs = s_awv && m_awrdy && aw_ok;
    rl_hs = s_rv && s_rlast && s_rrdy;
    b_hs  = s_bv && s_brdy;
    rd_n = clamp(m_rd + int'(ar_hs) + int'(aw_hs && s_atop[5]) - int'(rl_hs), MaxR);
    wr_n = clamp(m_wr + int'(aw_hs) - int'(b_hs), MaxW);
    case (m_mode)
      0: if (flush) m_mode = 1;
      1: if (!flush) m_mode = 0; else if (rd_n == 0 && wr_n == 0) m_mode = 2;
      default: if (!flush) m_mode = 0;
    endcase
    if (m_tc == ToCyc) m_to = 1'b1;
    m_tc = (busy_e && !rl_hs && !b_hs) ? clamp(m_tc + 1, ToCyc) : 0;
    m_rd = rd_n;
    m_wr = wr_n;
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_rd = 0; m_wr = 0; m_mode = 0; m_tc = 0; m_to = 1'b0;
  endtask

  initial begin
    clear();
    drive();
    #1;
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flushed", flushed, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Read cap: third AR held off until an R-last frees a slot.
    phase = "max_reads";
    s_arv = 1;
    repeat (3) step();
    chk("third_ar_blocked", slv_rsp.ar_ready, 0);
    chk("rd_at_cap", rd_cnt, 2);
    s_rv = 1; s_rlast = 1;
    step();
    s_rv = 0; s_rlast = 0;
    step();
    s_arv = 0;
    chk("third_ar_taken", rd_cnt, 2);
    s_rv = 1; s_rlast = 1;
    repeat (2) step();
    clear();

    // Write cap with B arriving while AW waits.
    phase = "max_writes";
    s_awv = 1;
    repeat (4) step();
    s_bv = 1;
    step();
    s_bv = 0;
    step();
    s_awv = 0;
    chk("wr_back_at_cap", wr_cnt, 4);
    s_bv = 1;
    repeat (4) step();
    clear();

    // Read-returning ATOP needs read headroom as well as write headroom.
    phase = "atop";
    s_arv = 1;
    step();
    s_arv = 0; s_awv = 1; s_atop = 6'b100001;
    step();
    chk("atop_rd", rd_cnt, 2);
    chk("atop_wr", wr_cnt, 1);
    repeat (2) step();
    s_rv = 1; s_rlast = 1;
    step();
    s_rv = 0; s_rlast = 0;
    step();
    s_awv = 0; s_atop = 6'b0;
    chk("atop2_wr", wr_cnt, 2);
    s_rv = 1; s_rlast = 1; s_bv = 1;
    repeat (2) step();
    clear();

    // Flush with traffic outstanding, then release and resume.
    phase = "flush";
    s_arv = 1; s_awv = 1;
    repeat (2) step();
    flush = 1;
    repeat (3) step();
    s_rv = 1; s_rlast = 1;
    repeat (2) step();
    s_rv = 0; s_rlast = 0; s_bv = 1;
    repeat (3) step();
    s_bv = 0;
    chk("flushed_after_last_b", flushed, 1);
    repeat (2) step();
    flush = 0;
    repeat (2) step();
    s_arv = 0; s_awv = 0;
    chk("resumed_rd", rd_cnt, 1);
    s_rv = 1; s_rlast = 1; s_bv = 1;
    step();
    clear();

    // Flush aborted before drained.
    phase = "abort";
    s_arv = 1;
    step();
    s_arv = 0; flush = 1;
    repeat (2) step();
    flush = 0;
    step();
    s_arv = 1;
    step();
    s_arv = 0; s_awv = 1;
    step();
    s_awv = 0;

    // Asynchronous reset mid-burst.
    phase = "async_reset";
    chk("pre_reset_rd", rd_cnt, 2);
    drive();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_cnt", rd_cnt, 0);
    chk("arst_wr_cnt", wr_cnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_flushed", flushed, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear();

`ifdef PICOBELLO_TXN_THROTTLE_TIMEOUT_EN
    phase = "timeout";
    s_arv = 1;
    step();
    s_arv = 0;
    repeat (20) step();
    chk("timeout_set", timeout, 1);
    s_rv = 1; s_rlast = 1;
    step();
    clear();
    step();
    chk("timeout_sticky", timeout, 1);
`endif

    phase = "random";
    repeat (400) begin
      s_arv   = 1'($urandom_range(0, 1));
      s_awv   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: s_atop = 6'b100001;
        1: s_atop = 6'b010001;
        default: s_atop = 6'b0;
      endcase
      s_wv    = 1'($urandom_range(0, 1));
      s_rlast = 1'($urandom_range(0, 1));
      s_rv    = (m_rd > 0) && ($urandom_range(0, 2) == 0);
      s_bv    = (m_wr > 0) && ($urandom_range(0, 2) == 0);
      s_rrdy  = ($urandom_range(0, 3) != 0);
      s_brdy  = ($urandom_range(0, 3) != 0);
      m_arrdy = ($urandom_range(0, 3) != 0);
      m_awrdy = ($urandom_range(0, 3) != 0);
      m_wrdy  = 1'($urandom_range(0, 1));
      s_rdata = {$urandom, $urandom};
      if ($urandom_range(0, 24) == 0) flush = ~flush;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
